dest_pipe: RTL and testbench

- Parametrised successor to the single-stage write-register selector in the 8-bit datapath.
- Decodes the destination register from the instruction in one of four modes: rt, rd, link, none.
- Carries the destination and its write enable through a DEPTH-stage in-flight pipeline with stall and flush.
- Presents the write-back destination to the register file and raises combinational RAW-hazard flags for the decoding instruction's rs/rt fields.

---
 rtl/dest_pipe_pkg.sv | 24 ++
 rtl/dest_pipe_decode.sv | 30 +++
 rtl/dest_pipe.sv | 101 ++++++++++
 tb/tb_dest_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dest_pipe_pkg.sv
// rtl/dest_pipe_pkg.sv - shared encodings, field defaults and stage record for the destination pipeline
package dest_pipe_pkg;

    typedef enum logic [1:0] {
        REGDST_RT   = 2'd0,
        REGDST_RD   = 2'd1,
        REGDST_LINK = 2'd2,
        REGDST_NONE = 2'd3
    } regdst_e;

    localparam int RS_LSB_DEF = 4;
    localparam int RT_LSB_DEF = 2;
    localparam int RD_LSB_DEF = 0;

    // Widest register address a stage can carry; narrower addresses are zero-extended.
    localparam int DEST_MAX_W = 8;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [DEST_MAX_W-1:0] dest;
    } stage_t;

endpackage

// File: rtl/dest_pipe_decode.sv
// rtl/dest_pipe_decode.sv - destination field/mode select and write-enable qualification
module dest_decode
    import dest_pipe_pkg::*;
#(
    parameter int REG_W    = 2,
    parameter int LINK_REG = 3,
    parameter int ZERO_HW  = 0
) (
    input  logic [REG_W-1:0] rt_field,
    input  logic [REG_W-1:0] rd_field,
    input  logic [1:0]       regdst,
    input  logic             reg_write,
    output logic [REG_W-1:0] dest,
    output logic             we
);

    // Pick the destination by mode, then drop the write for "no destination" or a hardwired zero register.
    always_comb begin
        dest = '0;
        case (regdst_e'(regdst))
            REGDST_RT:   dest = rt_field;
            REGDST_RD:   dest = rd_field;
            REGDST_LINK: dest = REG_W'(LINK_REG);
            REGDST_NONE: dest = '0;
            default:     dest = '0;
        endcase
        we = reg_write && (regdst != REGDST_NONE) && !((ZERO_HW != 0) && (dest == '0));
    end

endmodule

// File: rtl/dest_pipe.sv
// rtl/dest_pipe.sv - in-flight destination pipeline with stall/flush, write-back output and RAW hazard flags
module dest_pipe
    import dest_pipe_pkg::*;
#(
    parameter int INSTR_W  = 8,
    parameter int REG_W    = 2,
    parameter int RS_LSB   = RS_LSB_DEF,
    parameter int RT_LSB   = RT_LSB_DEF,
    parameter int RD_LSB   = RD_LSB_DEF,
    parameter int LINK_REG = 3,
    parameter int DEPTH    = 3,
    parameter int ZERO_HW  = 0
) (
    input  logic               Clk,
    input  logic               Clear_n,
    input  logic               In_Valid,
    input  logic               Stall,
    input  logic               Flush,
    input  logic [1:0]         RegDst,
    input  logic               Reg_Write,
    input  logic [INSTR_W-1:0] Instruction,
    output logic [REG_W-1:0]   Write_Register,
    output logic               Write_Enable,
    output logic               Hazard_Rs,
    output logic               Hazard_Rt,
    output logic               Busy
);

    logic [REG_W-1:0] rs_f;
    logic [REG_W-1:0] rt_f;
    logic [REG_W-1:0] rd_f;
    logic [REG_W-1:0] dec_dest;
    logic             dec_we;
    logic             accept;
    stage_t           in_stage;
    stage_t           stg [DEPTH];
    logic             match_rs;
    logic             match_rt;

    assign rs_f = Instruction[RS_LSB +: REG_W];
    assign rt_f = Instruction[RT_LSB +: REG_W];
    assign rd_f = Instruction[RD_LSB +: REG_W];

    dest_decode #(
        .REG_W    (REG_W),
        .LINK_REG (LINK_REG),
        .ZERO_HW  (ZERO_HW)
    ) u_decode (
        .rt_field  (rt_f),
        .rd_field  (rd_f),
        .regdst    (RegDst),
        .reg_write (Reg_Write),
        .dest      (dec_dest),
        .we        (dec_we)
    );

    // Flush outranks In_Valid: a flushed or stalled instruction never enters stage 0.
    always_comb begin
        accept         = In_Valid && !Stall && !Flush;
        in_stage       = '0;
        in_stage.valid = 1'b1;
        in_stage.we    = dec_we;
        in_stage.dest  = DEST_MAX_W'(dec_dest);
    end

    // Stage shift register: stall freezes every stage; flush bubbles all but the committed last stage.
    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= '0;
            end
        end else if (!Stall) begin
            stg[0] <= accept ? in_stage : '0;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= (Flush && (i < DEPTH - 1)) ? '0 : stg[i-1];
            end
        end
    end

    // Compare source fields against pending writes; the last stage is excluded since the register file forwards it.
    always_comb begin
        match_rs = 1'b0;
        match_rt = 1'b0;
        Busy     = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (stg[i].valid && stg[i].we) begin
                if (stg[i].dest == DEST_MAX_W'(rs_f)) match_rs = 1'b1;
                if (stg[i].dest == DEST_MAX_W'(rt_f)) match_rt = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (stg[i].valid && stg[i].we) Busy = 1'b1;
        end
        Hazard_Rs = In_Valid && match_rs && !((ZERO_HW != 0) && (rs_f == '0));
        Hazard_Rt = In_Valid && match_rt && !((ZERO_HW != 0) && (rt_f == '0));
    end

    assign Write_Register = stg[DEPTH-1].dest[REG_W-1:0];
    assign Write_Enable   = stg[DEPTH-1].we;

endmodule

// File: tb/tb_dest_pipe.sv
// tb/tb_dest_pipe.sv - scoreboard bench for dest_pipe
module tb_dest_pipe;

    logic       Clk = 1'b0;
    logic       Clear_n = 1'b0;
    logic       In_Valid = 1'b0;
    logic       Stall = 1'b0;
    logic       Flush = 1'b0;
    logic [1:0] RegDst = 2'd0;
    logic       Reg_Write = 1'b0;
    logic [7:0] Instruction = 8'd0;
    logic [1:0] Write_Register, z_Write_Register;
    logic       Write_Enable, Hazard_Rs, Hazard_Rt, Busy;
    logic       z_Write_Enable, z_Hazard_Rs, z_Hazard_Rt, z_Busy;

    int         errors = 0;
    int         checks = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_d;
    logic       mon_adv;

    dest_pipe dut (
        .Clk(Clk), .Clear_n(Clear_n), .In_Valid(In_Valid), .Stall(Stall), .Flush(Flush),
        .RegDst(RegDst), .Reg_Write(Reg_Write), .Instruction(Instruction),
        .Write_Register(Write_Register), .Write_Enable(Write_Enable),
        .Hazard_Rs(Hazard_Rs), .Hazard_Rt(Hazard_Rt), .Busy(Busy)
    );

    dest_pipe #(.ZERO_HW(1)) dut_z (
        .Clk(Clk), .Clear_n(Clear_n), .In_Valid(In_Valid), .Stall(Stall), .Flush(Flush),
        .RegDst(RegDst), .Reg_Write(Reg_Write), .Instruction(Instruction),
        .Write_Register(z_Write_Register), .Write_Enable(z_Write_Enable),
        .Hazard_Rs(z_Hazard_Rs), .Hazard_Rt(z_Hazard_Rt), .Busy(z_Busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [1:0] model_dest(input logic [7:0] ins, input logic [1:0] mode);
        case (mode)
            2'd0:    return ins[3:2];
            2'd1:    return ins[1:0];
            2'd2:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Every write-back on an advancing edge must match the oldest expected destination.
    always @(posedge Clk) begin
        mon_adv = Clear_n && !Stall;
        #1;
        if (mon_adv && Clear_n && Write_Enable) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got write to %0d, expected no write-back", Write_Register);
            end else begin
                exp_d = exp_q.pop_front();
                if (Write_Register !== exp_d) begin
                    errors++;
                    $display("FAIL wb_dest: got %0d, expected %0d", Write_Register, exp_d);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] ins, input logic [1:0] mode, input logic rw);
        In_Valid = v; Instruction = ins; RegDst = mode; Reg_Write = rw;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 8'd0, 2'd0, 1'b0);
    endtask

    task automatic tick();
        if (Clear_n && In_Valid && !Stall && !Flush && Reg_Write && RegDst != 2'd3)
            exp_q.push_back(model_dest(Instruction, RegDst));
        @(negedge Clk);
    endtask

    task automatic idle();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset();
        Clear_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge Clk);
        checks++; if (Write_Register !== 2'd0) begin errors++; $display("FAIL reset_wr: got %0d want 0", Write_Register); end
        checks++; if (Write_Enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", Write_Enable); end
        checks++; if ({Hazard_Rs, Hazard_Rt} !== 2'b00) begin errors++; $display("FAIL reset_hz: got %b want 00", {Hazard_Rs, Hazard_Rt}); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", Busy); end
        Clear_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_basic();
        drive(1'b1, 8'b01_10_11_01, 2'd1, 1'b1);
        tick();
        checks++; if ({Busy, Write_Enable} !== 2'b10) begin errors++; $display("FAIL basic_e1: got busy/we %b want 10", {Busy, Write_Enable}); end
        idle();
        checks++; if ({Busy, Write_Enable} !== 2'b10) begin errors++; $display("FAIL basic_e2: got busy/we %b want 10", {Busy, Write_Enable}); end
        idle();
        checks++; if ({Busy, Write_Enable, Write_Register} !== 4'b1101) begin errors++; $display("FAIL basic_e3: got busy/we/wr %b want 1101", {Busy, Write_Enable, Write_Register}); end
        idle();
        checks++; if ({Busy, Write_Enable} !== 2'b00) begin errors++; $display("FAIL basic_e4: got busy/we %b want 00", {Busy, Write_Enable}); end
    endtask

    task automatic test_modes();
        drive(1'b1, 8'b01_10_11_01, 2'd0, 1'b1); tick();
        drive(1'b1, 8'b01_10_11_01, 2'd2, 1'b1); tick();
        drive(1'b1, 8'b01_10_11_01, 2'd3, 1'b1); tick();
        checks++; if ({Write_Enable, Write_Register} !== 3'b111) begin errors++; $display("FAIL mode_rt: got we/wr %b want 111", {Write_Enable, Write_Register}); end
        idle();
        checks++; if ({Write_Enable, Write_Register} !== 3'b111) begin errors++; $display("FAIL mode_link: got we/wr %b want 111", {Write_Enable, Write_Register}); end
        idle();
        checks++; if ({Busy, Write_Enable} !== 2'b00) begin errors++; $display("FAIL mode_none: got busy/we %b want 00", {Busy, Write_Enable}); end
        idle();
    endtask

    task automatic test_hazard();
        drive(1'b1, 8'b00_00_00_10, 2'd1, 1'b1);
        tick();
        drive(1'b1, 8'b00_10_01_00, 2'd3, 1'b0); #1;
        checks++; if ({Hazard_Rs, Hazard_Rt} !== 2'b10) begin errors++; $display("FAIL hz_rs_s0: got %b want 10", {Hazard_Rs, Hazard_Rt}); end
        drive(1'b1, 8'b00_01_10_00, 2'd3, 1'b0); #1;
        checks++; if ({Hazard_Rs, Hazard_Rt} !== 2'b01) begin errors++; $display("FAIL hz_rt_s0: got %b want 01", {Hazard_Rs, Hazard_Rt}); end
        tick();
        drive(1'b1, 8'b00_10_10_00, 2'd3, 1'b0); #1;
        checks++; if ({Hazard_Rs, Hazard_Rt} !== 2'b11) begin errors++; $display("FAIL hz_both_s1: got %b want 11", {Hazard_Rs, Hazard_Rt}); end
        In_Valid = 1'b0; #1;
        checks++; if ({Hazard_Rs, Hazard_Rt} !== 2'b00) begin errors++; $display("FAIL hz_invalid: got %b want 00", {Hazard_Rs, Hazard_Rt}); end
        tick();
        drive(1'b1, 8'b00_10_00_00, 2'd3, 1'b0); #1;
        checks++; if (Hazard_Rs !== 1'b0) begin errors++; $display("FAIL hz_last_excluded: got %0b want 0", Hazard_Rs); end
        repeat (3) idle();
    endtask

    task automatic test_stall();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 8'(i), 2'd1, 1'b1);
            tick();
        end
        checks++; if ({Write_Enable, Write_Register} !== 3'b101) begin errors++; $display("FAIL stall_pre: got we/wr %b want 101", {Write_Enable, Write_Register}); end
        Stall = 1'b1;
        drive(1'b1, 8'b00_00_00_10, 2'd1, 1'b1);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if ({Busy, Write_Enable, Write_Register} !== 4'b1101) begin errors++; $display("FAIL stall_hold%0d: got busy/we/wr %b want 1101", c, {Busy, Write_Enable, Write_Register}); end
        end
        Stall = 1'b0;
        idle();
        checks++; if ({Write_Enable, Write_Register} !== 3'b110) begin errors++; $display("FAIL stall_resume2: got we/wr %b want 110", {Write_Enable, Write_Register}); end
        idle();
        checks++; if ({Write_Enable, Write_Register} !== 3'b111) begin errors++; $display("FAIL stall_resume3: got we/wr %b want 111", {Write_Enable, Write_Register}); end
        idle();
        checks++; if (Write_Enable !== 1'b0) begin errors++; $display("FAIL stall_drain: got we %0b want 0", Write_Enable); end
    endtask

    task automatic test_flush();
        drive(1'b1, 8'b00_00_00_01, 2'd1, 1'b1); tick();
        drive(1'b1, 8'b00_00_00_10, 2'd1, 1'b1); tick();
        Flush = 1'b1;
        drive(1'b1, 8'b00_00_00_11, 2'd1, 1'b1);
        // dest 2 sits in stage 0 and is discarded by the flush
        void'(exp_q.pop_back());
        tick();
        Flush = 1'b0;
        checks++; if ({Write_Enable, Write_Register} !== 3'b101) begin errors++; $display("FAIL flush_commit: got we/wr %b want 101", {Write_Enable, Write_Register}); end
        idle();
        checks++; if ({Busy, Write_Enable} !== 2'b00) begin errors++; $display("FAIL flush_dropped: got busy/we %b want 00", {Busy, Write_Enable}); end
        idle();
        checks++; if (Write_Enable !== 1'b0) begin errors++; $display("FAIL flush_after: got we %0b want 0", Write_Enable); end
    endtask

    task automatic test_zero_hw();
        drive(1'b1, 8'b00_00_00_00, 2'd1, 1'b1);
        tick();
        drive(1'b1, 8'b00_00_01_00, 2'd3, 1'b0); #1;
        checks++; if (Hazard_Rs !== 1'b1) begin errors++; $display("FAIL zero_main_hz: got %0b want 1", Hazard_Rs); end
        checks++; if (z_Hazard_Rs !== 1'b0) begin errors++; $display("FAIL zero_hz_rs: got %0b want 0", z_Hazard_Rs); end
        tick();
        idle();
        checks++; if ({z_Busy, z_Write_Enable} !== 2'b00) begin errors++; $display("FAIL zero_we: got busy/we %b want 00", {z_Busy, z_Write_Enable}); end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 8'(i), 2'd1, 1'b1);
            tick();
        end
        checks++; if ({z_Write_Enable, z_Write_Register} !== 3'b101) begin errors++; $display("FAIL zero_nonzero_wb: got we/wr %b want 101", {z_Write_Enable, z_Write_Register}); end
        idle_inputs();
        #2;
        Clear_n = 1'b0;
        exp_q.delete();
        #1;
        checks++; if ({Busy, Write_Enable} !== 2'b00) begin errors++; $display("FAIL rst_mid_main: got busy/we %b want 00", {Busy, Write_Enable}); end
        checks++; if ({z_Busy, z_Write_Enable} !== 2'b00) begin errors++; $display("FAIL rst_mid_z: got busy/we %b want 00", {z_Busy, z_Write_Enable}); end
        @(negedge Clk);
        Clear_n = 1'b1;
        repeat (4) idle();
        checks++; if ({Busy, Write_Enable} !== 2'b00) begin errors++; $display("FAIL rst_after: got busy/we %b want 00", {Busy, Write_Enable}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_hazard();
        test_stall();
        test_flush();
        test_zero_hw();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending write-backs, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
